// File: rtl/dmem_responder.sv
// Data-side SRAM responder: byte-lane writes, registered read with LATENCY-cycle timing and stall request.
// Optional `DMEM_RANGE_CHECK_EN adds a sticky data_sram_err flag for out-of-range addresses.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic        data_sram_err
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam bit         MULTI    = (LATENCY > 1);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  logic [31:0]       mem [2**ADDR_W];
  state_t            state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] raddr_q;
  logic              raddr_oor_q;

  logic [ADDR_W-1:0] index;
  logic              accept;
  logic              is_write;
  logic              oor;
  logic              unused_addr_bits;

  assign index    = data_sram_addr[ADDR_W+1:2];
  assign accept   = (state == IDLE) && data_sram_en;
  assign is_write = |data_sram_wen;

`ifdef DMEM_RANGE_CHECK_EN
  assign oor              = |data_sram_addr[31:ADDR_W+2];
  assign unused_addr_bits = ^data_sram_addr[1:0];
`else
  // Upper address bits alias into the RAM when range checking is off.
  assign oor              = 1'b0;
  assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};
`endif

  always_ff @(posedge clk) begin
    if (accept && is_write && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      raddr_q         <= '0;
      raddr_oor_q     <= 1'b0;
      data_sram_rdata <= 32'd0;
`ifdef DMEM_RANGE_CHECK_EN
      data_sram_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef DMEM_RANGE_CHECK_EN
            if (oor) data_sram_err <= 1'b1;
`endif
            if (!is_write) begin
              if (!MULTI) begin
                data_sram_rdata <= oor ? 32'd0 : mem[index];
              end else begin
                state       <= WAIT;
                cnt         <= CNT_INIT;
                raddr_q     <= index;
                raddr_oor_q <= oor;
              end
            end
          end
        end
        WAIT: begin
          // Requests seen here are the frozen pipeline re-presenting; they are dropped.
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            data_sram_rdata <= raddr_oor_q ? 32'd0 : mem[raddr_q];
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stallreq = MULTI && data_sram_en && !is_write;
        WAIT:    stallreq = (cnt > 3'd1);
        default: stallreq = 1'b0;
      endcase
    end
  end

endmodule
